// File: rtl/main_mem_arbiter.sv
// Main-memory arbiter: shares one memory port between icache fills and
// dcache reads/writebacks, one transaction outstanding at a time.
//
// state | meaning
// IDLE  | no transaction; requesters may be granted
// ISSUE | mem_req_valid asserted with latched fields, waiting for mem_req_ready
// WAIT  | request taken by memory, waiting for mem_resp_valid
module main_mem_arbiter #(
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int BLOCK_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ic_req_valid,
  output logic                        ic_req_ready,
  input  logic [BLOCK_ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                        ic_flush,
  output logic                        ic_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] ic_resp_data,
  input  logic                        dc_req_valid,
  output logic                        dc_req_ready,
  input  logic                        dc_req_we,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dc_req_wdata,
  output logic                        dc_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dc_resp_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_data,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                      state_q, state_d;
  logic                        last_dc_q, last_dc_d;   // 1: dcache got the last grant
  logic                        owner_dc_q, owner_dc_d;
  logic                        drop_q, drop_d;
  logic                        we_q, we_d;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                        ic_resp_valid_q, ic_resp_valid_d;
  logic [BLOCK_DATA_WIDTH-1:0] ic_resp_data_q, ic_resp_data_d;
  logic                        dc_resp_valid_q, dc_resp_valid_d;
  logic [BLOCK_DATA_WIDTH-1:0] dc_resp_data_q, dc_resp_data_d;

  logic ic_elig, grant_ic, grant_dc, can_grant, ic_acc, dc_acc;

  // A flushed icache request is not eligible; on a tie the requester that
  // did not win last time is granted.
  assign ic_elig   = ic_req_valid & ~ic_flush;
  assign grant_dc  = dc_req_valid & (~ic_elig | ~last_dc_q);
  assign grant_ic  = ic_elig & (~dc_req_valid | last_dc_q);
  assign can_grant = (state_q == IDLE) & ~rst;

  assign ic_req_ready = can_grant & grant_ic;
  assign dc_req_ready = can_grant & grant_dc;
  assign ic_acc       = ic_req_valid & ic_req_ready;
  assign dc_acc       = dc_req_valid & dc_req_ready;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign busy          = (state_q != IDLE);
  assign ic_resp_valid = ic_resp_valid_q;
  assign ic_resp_data  = ic_resp_data_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign dc_resp_data  = dc_resp_data_q;

  // Next-state: accept, issue, wait for response, route or drop it.
  always_comb begin
    state_d         = state_q;
    last_dc_d       = last_dc_q;
    owner_dc_d      = owner_dc_q;
    drop_d          = drop_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    ic_resp_valid_d = 1'b0;
    ic_resp_data_d  = ic_resp_data_q;
    dc_resp_valid_d = 1'b0;
    dc_resp_data_d  = dc_resp_data_q;
    case (state_q)
      IDLE: begin
        if (dc_acc) begin
          owner_dc_d = 1'b1;
          last_dc_d  = 1'b1;
          we_d       = dc_req_we;
          addr_d     = dc_req_addr;
          wdata_d    = dc_req_wdata;
          state_d    = ISSUE;
        end else if (ic_acc) begin
          owner_dc_d = 1'b0;
          last_dc_d  = 1'b0;
          we_d       = 1'b0;
          addr_d     = ic_req_addr;
          wdata_d    = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!owner_dc_q && ic_flush) drop_d = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (!owner_dc_q && ic_flush) drop_d = 1'b1;
        if (mem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_dc_q) begin
            dc_resp_valid_d = 1'b1;
            dc_resp_data_d  = mem_resp_data;
          end else if (!drop_q && !ic_flush) begin
            ic_resp_valid_d = 1'b1;
            ic_resp_data_d  = mem_resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      last_dc_q       <= 1'b0;
      owner_dc_q      <= 1'b0;
      drop_q          <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      ic_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= '0;
      dc_resp_valid_q <= 1'b0;
      dc_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      last_dc_q       <= last_dc_d;
      owner_dc_q      <= owner_dc_d;
      drop_q          <= drop_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      ic_resp_data_q  <= ic_resp_data_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      dc_resp_data_q  <= dc_resp_data_d;
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: requesters, memory and a
// transaction-level model are driven from one cycle task; a separate
// monitor pops expected responses whenever a resp_valid is seen.
module tb_main_mem_arbiter;
  localparam int AW = 29;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_req_valid = 1'b0, ic_req_ready, ic_flush = 1'b0, ic_resp_valid;
  logic [AW-1:0] ic_req_addr = '0;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req_valid = 1'b0, dc_req_ready, dc_req_we = 1'b0, dc_resp_valid;
  logic [AW-1:0] dc_req_addr = '0;
  logic [DW-1:0] dc_req_wdata = '0, dc_resp_data;
  logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_we, mem_resp_valid = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data = '0;
  logic          busy;

  always #5 clk = ~clk;

  main_mem_arbiter #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_flush(ic_flush), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct packed { logic [DW-1:0] data; logic [31:0] due; } rsp_t;

  int unsigned checks = 0, failures = 0, cyc = 0;
  req_t ic_pend[$], dc_pend[$], exp_mem[$];
  rsp_t exp_ic[$], exp_dc[$];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];

  // transaction-level model of the arbiter
  bit            m_last_dc, m_busy, m_req_out, m_wait, m_owner_ic, m_drop;
  int            m_resp_cnt;
  logic [DW-1:0] m_resp_data;

  // stimulus knobs
  bit rst_next = 1'b1, flush_in_wait = 1'b0, force_spur = 1'b0;
  int mem_ready_pct = 100, dly_min = 0, dly_max = 0, spur_pct = 0;
  int flush_pct = 0, withdraw_pct = 0, hold_cnt = 0;

  // observation logs
  bit            grant_log[$];
  logic [AW-1:0] addr_log[$];
  int unsigned   acc_cyc_ic, ic_rsp_cyc, ic_rsp_cnt = 0, dc_rsp_cnt = 0;
  logic [DW-1:0] ic_rsp_seen, last_ic = '0, last_dc = '0;
  rsp_t          mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic reset_model();
    ic_pend.delete(); dc_pend.delete(); exp_mem.delete(); exp_ic.delete(); exp_dc.delete();
    m_last_dc = 0; m_busy = 0; m_req_out = 0; m_wait = 0; m_owner_ic = 0; m_drop = 0;
    hold_cnt = 0; flush_in_wait = 0;
  endtask

  // Response monitor: each resp pulse must match the oldest expected one, in
  // the cycle it is due; between pulses the data must hold.
  always @(negedge clk) begin
    if (rst) begin
      chk("ic_valid_rst", ic_resp_valid, 0);
      chk("dc_valid_rst", dc_resp_valid, 0);
      chk("ic_data_rst", ic_resp_data, 0);
      chk("dc_data_rst", dc_resp_data, 0);
      last_ic = '0; last_dc = '0;
    end else begin
      if (ic_resp_valid) begin
        ic_rsp_cnt++; ic_rsp_cyc = cyc; ic_rsp_seen = ic_resp_data;
        chk("ic_resp_expected", exp_ic.size() > 0, 1);
        if (exp_ic.size() > 0) begin
          mon_e = exp_ic.pop_front();
          chk("ic_resp_data", ic_resp_data, mon_e.data);
          chk("ic_resp_cycle", cyc, mon_e.due);
        end
        last_ic = ic_resp_data;
      end else chk("ic_data_hold", ic_resp_data, last_ic);
      if (dc_resp_valid) begin
        dc_rsp_cnt++;
        chk("dc_resp_expected", exp_dc.size() > 0, 1);
        if (exp_dc.size() > 0) begin
          mon_e = exp_dc.pop_front();
          chk("dc_resp_data", dc_resp_data, mon_e.data);
          chk("dc_resp_cycle", cyc, mon_e.due);
        end
        last_dc = dc_resp_data;
      end else chk("dc_data_hold", dc_resp_data, last_dc);
    end
  end

  // One clock: drive all inputs after the edge, check and update model at negedge.
  task automatic step();
    req_t r;
    bit ic_v, dc_v, ic_e, e_ic, e_dc;
    @(posedge clk);
    cyc++;
    #1;
    rst  = rst_next;
    ic_v = (ic_pend.size() > 0) && ($urandom_range(99) >= withdraw_pct);
    dc_v = (dc_pend.size() > 0) && ($urandom_range(99) >= withdraw_pct);
    ic_req_valid = ic_v;
    ic_req_addr  = (ic_pend.size() > 0) ? ic_pend[0].addr : AW'($urandom);
    dc_req_valid = dc_v;
    if (dc_pend.size() > 0) begin
      dc_req_we = dc_pend[0].we; dc_req_addr = dc_pend[0].addr; dc_req_wdata = dc_pend[0].wdata;
    end else begin
      dc_req_we = 1'($urandom); dc_req_addr = AW'($urandom); dc_req_wdata = {$urandom, $urandom};
    end
    ic_flush = ($urandom_range(99) < flush_pct);
    if (flush_in_wait && m_wait && m_owner_ic) begin
      ic_flush = 1'b1; flush_in_wait = 0;
    end
    if (m_req_out && hold_cnt > 0) begin
      mem_req_ready = 1'b0; hold_cnt--;
    end else mem_req_ready = ($urandom_range(99) < mem_ready_pct);
    if (m_wait && m_resp_cnt == 0) begin
      mem_resp_valid = 1'b1; mem_resp_data = m_resp_data;
    end else begin
      if (m_wait) m_resp_cnt--;
      mem_resp_valid = !m_wait && (force_spur || $urandom_range(99) < spur_pct);
      mem_resp_data  = {$urandom, $urandom};
    end
    force_spur = 0;

    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("mem_req_valid", mem_req_valid, m_req_out);
    if (rst) begin
      chk("mem_req_addr_rst", mem_req_addr, 0);
      chk("mem_req_we_rst", mem_req_we, 0);
      chk("mem_req_wdata_rst", mem_req_wdata, 0);
    end else if (m_req_out) begin
      chk("mem_req_addr", mem_req_addr, exp_mem[0].addr);
      chk("mem_req_we", mem_req_we, exp_mem[0].we);
      if (exp_mem[0].we) chk("mem_req_wdata", mem_req_wdata, exp_mem[0].wdata);
    end
    e_ic = 0; e_dc = 0;
    if (!rst && !m_busy) begin
      ic_e = ic_v && !ic_flush;
      if (ic_e && dc_v) begin
        if (m_last_dc) e_ic = 1; else e_dc = 1;
      end else begin
        e_ic = ic_e; e_dc = dc_v;
      end
    end
    chk("ic_req_ready", ic_req_ready, e_ic);
    chk("dc_req_ready", dc_req_ready, e_dc);
    if (!rst) begin
      if (m_busy && m_owner_ic && ic_flush) m_drop = 1;
      if (m_wait && mem_resp_valid) begin
        if (!m_owner_ic) exp_dc.push_back({mem_resp_data, 32'(cyc + 1)});
        else if (!m_drop) exp_ic.push_back({mem_resp_data, 32'(cyc + 1)});
        m_wait = 0; m_busy = 0; m_drop = 0;
      end else if (m_req_out && mem_req_ready) begin
        r = exp_mem.pop_front();
        addr_log.push_back(r.addr);
        if (r.we) begin
          mem_arr[r.addr] = r.wdata;
          m_resp_data = {$urandom, $urandom};
        end else if (mem_arr.exists(r.addr)) m_resp_data = mem_arr[r.addr];
        else m_resp_data = {35'h5a5a5, r.addr};
        m_req_out = 0; m_wait = 1;
        m_resp_cnt = $urandom_range(dly_max, dly_min);
      end else if (e_dc) begin
        r = dc_pend.pop_front();
        exp_mem.push_back(r);
        m_owner_ic = 0; m_last_dc = 1; m_busy = 1; m_req_out = 1;
        grant_log.push_back(1);
      end else if (e_ic && ic_v) begin
        r = ic_pend.pop_front();
        exp_mem.push_back(mk(1'b0, r.addr, '0));
        m_owner_ic = 1; m_last_dc = 0; m_busy = 1; m_req_out = 1; m_drop = 0;
        grant_log.push_back(0); acc_cyc_ic = cyc;
      end
    end
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((ic_pend.size() != 0 || dc_pend.size() != 0 || m_busy) && n < max) begin
      step(); n++;
    end
    chk({name, "_timeout"}, (ic_pend.size() != 0 || dc_pend.size() != 0 || m_busy), 0);
    step(); step();
  endtask

  initial begin
    int n0, n1;
    // reset and first tie (dcache first)
    step(); step();
    ic_pend.push_back(mk(1'b0, 29'h4063, '0));
    dc_pend.push_back(mk(1'b0, 29'h1000, '0));
    rst_next = 0;
    drain("tie", 40);
    chk("tie_first_grant_dc", grant_log.size() > 0 ? grant_log[0] : 1'b0, 1);
    chk("tie_second_grant_ic", grant_log.size() > 1 ? grant_log[1] : 1'b1, 0);
    chk("tie_addr0", addr_log.size() > 0 ? addr_log[0] : '0, 29'h1000);
    chk("tie_addr1", addr_log.size() > 1 ? addr_log[1] : '0, 29'h4063);

    // single icache fill at minimum latency
    mem_arr[29'h0123] = 64'h00f0049302010413;
    n0 = ic_rsp_cnt;
    ic_pend.push_back(mk(1'b0, 29'h0123, '0));
    drain("fill", 40);
    chk("fill_data", ic_rsp_seen, 64'h00f0049302010413);
    chk("fill_latency", ic_rsp_cyc - acc_cyc_ic, 3);
    chk("fill_count", ic_rsp_cnt - n0, 1);

    // dcache write with memory stalling 5 cycles, then read it back via icache
    n0 = dc_rsp_cnt;
    hold_cnt = 5;
    dc_pend.push_back(mk(1'b1, 29'h2000, 64'hDEADBEEFDEADBABE));
    drain("wr", 60);
    chk("wr_ack_count", dc_rsp_cnt - n0, 1);
    chk("wr_hold_used", hold_cnt, 0);
    ic_pend.push_back(mk(1'b0, 29'h2000, '0));
    drain("rd_back", 40);
    chk("rd_back_data", ic_rsp_seen, 64'hDEADBEEFDEADBABE);

    // flush during an icache fill drops it; dcache proceeds afterwards
    n0 = ic_rsp_cnt; n1 = dc_rsp_cnt;
    dly_min = 3; dly_max = 3; flush_in_wait = 1;
    ic_pend.push_back(mk(1'b0, 29'h0777, '0));
    drain("flush", 40);
    chk("flush_used", flush_in_wait, 0);
    chk("flush_no_resp", ic_rsp_cnt - n0, 0);
    dly_min = 0; dly_max = 0;
    dc_pend.push_back(mk(1'b0, 29'h0123, '0));
    drain("after_flush", 40);
    chk("after_flush_dc", dc_rsp_cnt - n1, 1);

    // continuous contention alternates starting with dcache after reset
    rst_next = 1; reset_model(); step();
    rst_next = 0;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      ic_pend.push_back(mk(1'b0, AW'(29'h100 + i), '0));
      dc_pend.push_back(mk(1'($urandom_range(1)), AW'(29'h200 + i), {$urandom, $urandom}));
    end
    drain("alt", 100);
    chk("alt_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("alt_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, (i % 2 == 0));

    // reset in WAIT, then a late memory response
    n0 = ic_rsp_cnt;
    dly_min = 4; dly_max = 4;
    ic_pend.push_back(mk(1'b0, 29'h0333, '0));
    for (int i = 0; i < 20 && !m_wait; i++) step();
    chk("rst_wait_reached", m_wait, 1);
    rst_next = 1; reset_model(); step(); step();
    rst_next = 0; force_spur = 1; step(); step(); step();
    chk("rst_no_resp", ic_rsp_cnt - n0, 0);
    chk("rst_busy", busy, 0);
    dly_min = 0;

    // randomized traffic with stalls, flushes, withdrawals and stray responses
    mem_ready_pct = 60; dly_max = 3; spur_pct = 15; flush_pct = 10; withdraw_pct = 20;
    for (int i = 0; i < 400; i++) begin
      if (ic_pend.size() < 2 && $urandom_range(3) == 0)
        ic_pend.push_back(mk(1'b0, AW'($urandom_range(15)), '0));
      if (dc_pend.size() < 2 && $urandom_range(3) == 0)
        dc_pend.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(15)), {$urandom, $urandom}));
      step();
    end
    drain("random", 2000);
    chk("exp_ic_empty", exp_ic.size(), 0);
    chk("exp_dc_empty", exp_dc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 Parameter BLOCK_ADDR_WIDTH, default 29, width of main-memory block address.
REQ-002 Parameter BLOCK_DATA_WIDTH, default 64, width of one main-memory block.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ic_req_valid / ic_req_ready  in / out  1 each  icache fill request handshake.
REQ-007 ic_req_addr  in  BLOCK_ADDR_WIDTH  icache fill block address.
REQ-008 ic_flush  in  1  frontend redirect; cancels outstanding icache fill.
REQ-009 ic_resp_valid / ic_resp_data  out  1 / BLOCK_DATA_WIDTH  icache fill return.
REQ-010 dc_req_valid / dc_req_ready  in / out  1 each  dcache request handshake.
REQ-011 dc_req_we, dc_req_addr, dc_req_wdata  in  1 / BLOCK_ADDR_WIDTH / BLOCK_DATA_WIDTH  dcache write-enable, block address, writeback data.
REQ-012 dc_resp_valid / dc_resp_data  out  1 / BLOCK_DATA_WIDTH  dcache read data or write ack.
REQ-013 mem_req_valid / mem_req_ready  out / in  1 each  memory request handshake.
REQ-014 mem_req_we, mem_req_addr, mem_req_wdata  out  1 / BLOCK_ADDR_WIDTH / BLOCK_DATA_WIDTH  memory request fields.
REQ-015 mem_resp_valid / mem_resp_data  in  1 / BLOCK_DATA_WIDTH  memory response (read data or write ack).
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one memory transaction outstanding at a time.
REQ-018 req_ready SHALL be asserted only in IDLE, only to the granted requester, combinationally from current valids and last_grant.
REQ-019 Arbitration: single valid -> that requester; both valid -> requester other than last_grant; last_grant updates on every accept.
REQ-020 ic_req_ready SHALL be 0 in any cycle ic_flush is 1; dcache may be granted that cycle.
REQ-021 On accept (valid & ready) at cycle N: latch owner, we (0 for icache), addr, wdata; go ISSUE at N+1.
REQ-022 ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready; on mem_req_ready go WAIT.
REQ-023 WAIT: on mem_resp_valid at cycle M, register mem_resp_data to owner's resp_data and pulse owner's resp_valid for exactly one cycle at M+1; go IDLE at M+1.
REQ-024 Minimum turnaround: accept at N, mem_req_ready at N+1, mem_resp_valid at N+2 -> resp_valid at N+3 and next accept possible at N+3.
REQ-025 Write ack: dc_resp_valid pulses as for reads; dc_resp_data = mem_resp_data unchanged.
REQ-026 resp_data outputs SHALL hold last returned value until the next response to that port.
REQ-027 ic_flush while owner=icache in ISSUE or WAIT SHALL set a drop flag: transaction completes to memory, ic_resp_valid suppressed, ic_resp_data unchanged; flag cleared on return to IDLE.
REQ-028 ic_flush SHALL never affect a dcache-owned transaction or dcache outputs.
REQ-029 ic_flush coincident with mem_resp_valid for an icache transaction SHALL drop that response.
REQ-030 mem_resp_valid in IDLE or ISSUE SHALL be ignored with no state or output change.
REQ-031 Requester deasserting valid before accept SHALL lose no state; no grant is recorded.

Reset
REQ-032 On rst: state=IDLE, last_grant=icache (first tie goes to dcache), drop flag=0.
REQ-033 On rst: all valid/ready outputs and busy=0; all data/addr/we outputs=0.
REQ-034 rst mid-transaction SHALL abandon it with no response pulse; late mem_resp_valid after reset ignored per REQ-030.

Verification
REQ-035 Both valid at first post-reset cycle, ic addr 0x4063, dc read addr 0x1000 -> dcache granted first, mem_req_addr=0x1000; icache served next with 0x4063.
REQ-036 Single icache read, mem ready immediately, mem returns 0x00f0049302010413 one cycle later -> ic_resp_valid one-cycle pulse with that data, 3 cycles after accept.
REQ-037 dc write addr 0x2000 wdata 0xDEADBEEFDEADBABE, mem_req_ready held low 5 cycles -> mem_req fields stable for all 5, dc_resp_valid pulses once after ack.
REQ-038 icache fill in WAIT, ic_flush pulse, then mem_resp_valid -> no ic_resp_valid, FSM returns IDLE, next dcache request accepted normally.
REQ-039 Both requesters continuously valid for 8 transactions -> grants strictly alternate dc, ic, dc, ic, ...
REQ-040 rst asserted in WAIT, then mem_resp_valid -> no resp pulse, busy=0, all outputs 0.
